// File: rtl/idexe_pkg.sv
// Shared constants for the ID/EXE pipeline register: forwarding-select
// encodings, default datapath widths and a small select helper.
package idexe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int ALUC_W_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    // Operand source selects used by the EXE-stage operand muxes
    localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // result of the instruction now in EXE
    localparam logic [1:0] FWD_WB  = 2'b10;  // result of the instruction now in MEM

    // The younger producer (EXE) always wins over the older one (MEM)
    function automatic logic [1:0] fwd_pick(input logic exe_hit, input logic mem_hit);
        logic [1:0] sel;
        if (exe_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/idexe_hazard.sv
// Combinational load-use hazard detection and forwarding-select generation
// for the instruction currently in ID.
module idexe_hazard
    import idexe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              id_valid,
    input  logic              uses_rt,
    input  logic              aluimm,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              evalid,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic [REG_AW-1:0] edestReg,
    input  logic              mwreg,
    input  logic [REG_AW-1:0] mdestReg,
    output logic              hazard,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb
);

    logic exe_wr_s;
    logic exe_hit_a_s;
    logic exe_hit_b_s;
    logic mem_hit_a_s;
    logic mem_hit_b_s;

    // Hazard when EXE holds a load whose target ID reads; forward selects from EXE/MEM matches
    always_comb begin
        exe_wr_s    = evalid & ewreg & (edestReg != {REG_AW{1'b0}});
        hazard      = id_valid & exe_wr_s & em2reg &
                      ((edestReg == rs) | (uses_rt & (edestReg == rt)));
        exe_hit_a_s = evalid & ewreg & ~em2reg & (edestReg == rs) & (rs != {REG_AW{1'b0}});
        exe_hit_b_s = evalid & ewreg & ~em2reg & (edestReg == rt) & (rt != {REG_AW{1'b0}});
        mem_hit_a_s = mwreg & (mdestReg == rs) & (rs != {REG_AW{1'b0}});
        mem_hit_b_s = mwreg & (mdestReg == rt) & (rt != {REG_AW{1'b0}});
        fwda        = fwd_pick(exe_hit_a_s, mem_hit_a_s);
        if (uses_rt & ~aluimm) begin
            fwdb = fwd_pick(exe_hit_b_s, mem_hit_b_s);
        end else begin
            fwdb = FWD_REG;
        end
    end

endmodule

// File: rtl/idexe_pipe_reg.sv
// ID/EXE pipeline register with load-use bubble insertion, flush, downstream
// freeze, registered forwarding selects and a saturating bubble counter.
module idexe_pipe_reg
    import idexe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int ALUC_W = ALUC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic              wmem,
    input  logic              aluimm,
    input  logic              uses_rt,
    input  logic [ALUC_W-1:0] aluc,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] destReg,
    input  logic [DATA_W-1:0] qa,
    input  logic [DATA_W-1:0] qb,
    input  logic [DATA_W-1:0] imm32,
    input  logic              flush,
    input  logic              exe_stall,
    input  logic              mwreg,
    input  logic [REG_AW-1:0] mdestReg,
    output logic              evalid,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ealuimm,
    output logic [ALUC_W-1:0] ealuc,
    output logic [REG_AW-1:0] edestReg,
    output logic [DATA_W-1:0] eqa,
    output logic [DATA_W-1:0] eqb,
    output logic [DATA_W-1:0] eimm32,
    output logic [1:0]        efwda,
    output logic [1:0]        efwdb,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              hazard_s;
    logic [1:0]        fwda_s;
    logic [1:0]        fwdb_s;

    logic              evalid_r;
    logic              ewreg_r;
    logic              em2reg_r;
    logic              ewmem_r;
    logic              ealuimm_r;
    logic [ALUC_W-1:0] ealuc_r;
    logic [REG_AW-1:0] edest_r;
    logic [DATA_W-1:0] eqa_r;
    logic [DATA_W-1:0] eqb_r;
    logic [DATA_W-1:0] eimm_r;
    logic [1:0]        efwda_r;
    logic [1:0]        efwdb_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    idexe_hazard #(.REG_AW(REG_AW)) u_hazard (
        .id_valid (id_valid),
        .uses_rt  (uses_rt),
        .aluimm   (aluimm),
        .rs       (rs),
        .rt       (rt),
        .evalid   (evalid_r),
        .ewreg    (ewreg_r),
        .em2reg   (em2reg_r),
        .edestReg (edest_r),
        .mwreg    (mwreg),
        .mdestReg (mdestReg),
        .hazard   (hazard_s),
        .fwda     (fwda_s),
        .fwdb     (fwdb_s)
    );

    // ID/IF must hold either while a bubble is inserted or while EXE is frozen
    assign stall_id = hazard_s | exe_stall;

    // EXE-stage register: freeze beats flush, flush beats bubble, bubble beats load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evalid_r  <= 1'b0;
            ewreg_r   <= 1'b0;
            em2reg_r  <= 1'b0;
            ewmem_r   <= 1'b0;
            ealuimm_r <= 1'b0;
            ealuc_r   <= {ALUC_W{1'b0}};
            edest_r   <= {REG_AW{1'b0}};
            eqa_r     <= {DATA_W{1'b0}};
            eqb_r     <= {DATA_W{1'b0}};
            eimm_r    <= {DATA_W{1'b0}};
            efwda_r   <= FWD_REG;
            efwdb_r   <= FWD_REG;
        end else if (!exe_stall) begin
            // Datapath fields are meaningless once the valid bits are cleared,
            // so they are captured unconditionally.
            em2reg_r  <= m2reg;
            ealuimm_r <= aluimm;
            ealuc_r   <= aluc;
            edest_r   <= destReg;
            eqa_r     <= qa;
            eqb_r     <= qb;
            eimm_r    <= imm32;
            efwda_r   <= fwda_s;
            efwdb_r   <= fwdb_s;
            if (flush || hazard_s) begin
                evalid_r <= 1'b0;
                ewreg_r  <= 1'b0;
                ewmem_r  <= 1'b0;
            end else begin
                evalid_r <= id_valid;
                ewreg_r  <= wreg & id_valid;
                ewmem_r  <= wmem & id_valid;
            end
        end
    end

    // Count inserted load-use bubbles, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (!exe_stall && !flush && hazard_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign evalid     = evalid_r;
    assign ewreg      = ewreg_r;
    assign em2reg     = em2reg_r;
    assign ewmem      = ewmem_r;
    assign ealuimm    = ealuimm_r;
    assign ealuc      = ealuc_r;
    assign edestReg   = edest_r;
    assign eqa        = eqa_r;
    assign eqb        = eqb_r;
    assign eimm32     = eimm_r;
    assign efwda      = efwda_r;
    assign efwdb      = efwdb_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Self-checking bench for idexe_pipe_reg: directed instruction sequences,
// a behavioural EXE-stage model compared every negedge, plus literal checks.
module tb_idexe_pipe_reg;

    logic        clk;
    logic        rst;
    logic        id_valid, wreg, m2reg, wmem, aluimm, uses_rt;
    logic [3:0]  aluc;
    logic [4:0]  rs, rt, destReg, mdestReg;
    logic [31:0] qa, qb, imm32;
    logic        flush, exe_stall, mwreg;

    logic        evalid, ewreg, em2reg, ewmem, ealuimm, stall_id;
    logic [3:0]  ealuc;
    logic [4:0]  edestReg;
    logic [31:0] eqa, eqb, eimm32;
    logic [1:0]  efwda, efwdb;
    logic [15:0] bubble_cnt;

    logic        d2_evalid, d2_ewreg, d2_em2reg, d2_ewmem, d2_ealuimm, d2_stall_id;
    logic [3:0]  d2_ealuc;
    logic [4:0]  d2_edestReg;
    logic [31:0] d2_eqa, d2_eqb, d2_eimm32;
    logic [1:0]  d2_efwda, d2_efwdb;
    logic [1:0]  d2_bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    idexe_pipe_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .wreg(wreg), .m2reg(m2reg),
        .wmem(wmem), .aluimm(aluimm), .uses_rt(uses_rt), .aluc(aluc), .rs(rs),
        .rt(rt), .destReg(destReg), .qa(qa), .qb(qb), .imm32(imm32),
        .flush(flush), .exe_stall(exe_stall), .mwreg(mwreg), .mdestReg(mdestReg),
        .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuimm(ealuimm), .ealuc(ealuc), .edestReg(edestReg), .eqa(eqa),
        .eqb(eqb), .eimm32(eimm32), .efwda(efwda), .efwdb(efwdb),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt)
    );

    idexe_pipe_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .wreg(wreg), .m2reg(m2reg),
        .wmem(wmem), .aluimm(aluimm), .uses_rt(uses_rt), .aluc(aluc), .rs(rs),
        .rt(rt), .destReg(destReg), .qa(qa), .qb(qb), .imm32(imm32),
        .flush(flush), .exe_stall(exe_stall), .mwreg(mwreg), .mdestReg(mdestReg),
        .evalid(d2_evalid), .ewreg(d2_ewreg), .em2reg(d2_em2reg), .ewmem(d2_ewmem),
        .ealuimm(d2_ealuimm), .ealuc(d2_ealuc), .edestReg(d2_edestReg), .eqa(d2_eqa),
        .eqb(d2_eqb), .eimm32(d2_eimm32), .efwda(d2_efwda), .efwdb(d2_efwdb),
        .stall_id(d2_stall_id), .bubble_cnt(d2_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model of the EXE stage ----------------
    logic        m_valid, m_wreg, m_load, m_wmem, m_aluimm;
    logic [3:0]  m_aluc;
    logic [4:0]  m_dest;
    logic [31:0] m_qa, m_qb, m_imm;
    logic [1:0]  m_fwda, m_fwdb;
    int          m_cnt, m_cnt2;

    // ID must wait when the instruction ahead is a load into a register ID reads
    function automatic logic m_hazard();
        logic reads;
        reads = (m_dest == rs) || (uses_rt && m_dest == rt);
        return id_valid && m_valid && m_wreg && m_load && m_dest != 5'd0 && reads;
    endfunction

    // Where the operand for register r should come from
    function automatic logic [1:0] m_src(input logic [4:0] r);
        if (r == 5'd0) return 2'd0;
        if (m_valid && m_wreg && !m_load && m_dest == r) return 2'd1;
        if (mwreg && mdestReg == r) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_wreg <= 1'b0; m_load <= 1'b0; m_wmem <= 1'b0;
            m_aluimm <= 1'b0; m_aluc <= 4'd0; m_dest <= 5'd0;
            m_qa <= 32'd0; m_qb <= 32'd0; m_imm <= 32'd0;
            m_fwda <= 2'd0; m_fwdb <= 2'd0; m_cnt <= 0; m_cnt2 <= 0;
        end else if (!exe_stall) begin
            m_valid  <= id_valid && !flush && !m_hazard();
            m_wreg   <= id_valid && wreg && !flush && !m_hazard();
            m_wmem   <= id_valid && wmem && !flush && !m_hazard();
            m_load   <= m2reg;
            m_aluimm <= aluimm;
            m_aluc   <= aluc;
            m_dest   <= destReg;
            m_qa     <= qa;
            m_qb     <= qb;
            m_imm    <= imm32;
            m_fwda   <= m_src(rs);
            m_fwdb   <= (uses_rt && !aluimm) ? m_src(rt) : 2'd0;
            if (!flush && m_hazard()) begin
                m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against model every negedge
    always @(negedge clk) begin
        if (!rst) begin
            chk("stall_id", 32'(stall_id), 32'(m_hazard() || exe_stall));
            chk("evalid", 32'(evalid), 32'(m_valid));
            chk("ewreg", 32'(ewreg), 32'(m_wreg));
            chk("ewmem", 32'(ewmem), 32'(m_wmem));
            chk("bubble_cnt", 32'(bubble_cnt), m_cnt);
            chk("bubble_cnt2", 32'(d2_bubble_cnt), m_cnt2);
            if (m_valid) begin
                chk("em2reg", 32'(em2reg), 32'(m_load));
                chk("ealuimm", 32'(ealuimm), 32'(m_aluimm));
                chk("ealuc", 32'(ealuc), 32'(m_aluc));
                chk("edestReg", 32'(edestReg), 32'(m_dest));
                chk("eqa", eqa, m_qa);
                chk("eqb", eqb, m_qb);
                chk("eimm32", eimm32, m_imm);
                chk("efwda", 32'(efwda), 32'(m_fwda));
                chk("efwdb", 32'(efwdb), 32'(m_fwdb));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic v, input logic w, input logic ld, input logic wm,
                          input logic ai, input logic ur, input logic [3:0] ac,
                          input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] d,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        id_valid = v; wreg = w; m2reg = ld; wmem = wm; aluimm = ai; uses_rt = ur;
        aluc = ac; rs = a_rs; rt = a_rt; destReg = d; qa = a; qb = b; imm32 = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zero"}, {evalid, ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg,
                             efwda, efwdb, 14'd0}, 32'd0);
        chk({tag, "_data"}, eqa | eqb | eimm32, 32'd0);
        chk({tag, "_cnt"}, 32'(bubble_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; exe_stall = 1'b0; mwreg = 1'b0; mdestReg = 5'd0;
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #2;
        chk_all_zero("reset");
        #1 rst = 1'b0;
        tick();

        // Load-use: lw r2, then add reads r2
        set_id(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 5'd1, 5'd0, 5'd2, 32'h11, 32'h22, 32'h40);
        tick();
        chk("lw_in_exe", {29'd0, evalid, em2reg, ewreg}, 32'd7);
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 5'd2, 5'd4, 5'd5, 32'h33, 32'h44, 32'h0);
        #1 chk("lu_stall", 32'(stall_id), 32'd1);
        tick();
        chk("lu_bubble", 32'(evalid), 32'd0);
        chk("lu_cnt", 32'(bubble_cnt), 32'd1);
        mwreg = 1'b1; mdestReg = 5'd2;
        #1 chk("lu_nostall", 32'(stall_id), 32'd0);
        tick();
        chk("lu_add_valid", 32'(evalid), 32'd1);
        chk("lu_fwda_wb", 32'(efwda), 32'd2);

        // EXE add writes r3, ID add reads r3 twice
        mwreg = 1'b0; mdestReg = 5'd0;
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 5'd1, 5'd1, 5'd3, 32'h5, 32'h6, 32'h0);
        tick();
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 5'd3, 5'd3, 5'd8, 32'h7, 32'h8, 32'h0);
        #1 chk("fwd_nostall", 32'(stall_id), 32'd0);
        tick();
        chk("fwd_exe_ab", {30'd0, efwda}, {30'd0, efwdb} & 32'd1 | 32'd0 + {30'd0, efwdb});
        chk("fwd_exe_a", 32'(efwda), 32'd1);
        chk("fwd_exe_b", 32'(efwdb), 32'd1);

        // r0 never forwards
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 5'd1, 5'd1, 5'd0, 32'h9, 32'h9, 32'h0);
        tick();
        mwreg = 1'b1; mdestReg = 5'd0;
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 5'd0, 5'd0, 5'd4, 32'ha, 32'hb, 32'h0);
        #1 chk("r0_nostall", 32'(stall_id), 32'd0);
        tick();
        chk("r0_fwda", 32'(efwda), 32'd0);

        // EXE and MEM both produce r7: EXE wins; rt ignored when aluimm
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 5'd1, 5'd0, 5'd7, 32'hc, 32'hd, 32'h0);
        tick();
        mwreg = 1'b1; mdestReg = 5'd7;
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 5'd7, 5'd7, 5'd9, 32'he, 32'hf, 32'h10);
        tick();
        chk("prio_fwda", 32'(efwda), 32'd1);
        chk("aluimm_fwdb", 32'(efwdb), 32'd0);

        // Freeze three cycles holding 0xDEADBEEF
        mwreg = 1'b0; mdestReg = 5'd0;
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 5'd1, 5'd2, 5'd6, 32'hDEADBEEF, 32'h1234, 32'h77);
        tick();
        exe_stall = 1'b1;
        set_id(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 5'd6, 5'd6, 5'd10, 32'h1, 32'h2, 32'h3);
        for (int i = 0; i < 3; i++) begin
            #1 chk("frz_stall", 32'(stall_id), 32'd1);
            tick();
            chk("frz_eqa", eqa, 32'hDEADBEEF);
            chk("frz_dest", {27'd0, edestReg}, 32'd6);
            chk("frz_ewmem", 32'(ewmem), 32'd1);
            chk("frz_cnt", 32'(bubble_cnt), 32'd1);
        end
        exe_stall = 1'b0;

        // Flush coinciding with a hazard
        set_id(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 5'd1, 5'd0, 5'd2, 32'h11, 32'h0, 32'h4);
        tick();
        flush = 1'b1;
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 5'd2, 5'd2, 5'd5, 32'h1, 32'h1, 32'h0);
        #1 chk("fh_stall", 32'(stall_id), 32'd1);
        tick();
        flush = 1'b0;
        chk("fh_evalid", 32'(evalid), 32'd0);
        chk("fh_ewreg", 32'(ewreg), 32'd0);
        chk("fh_cnt", 32'(bubble_cnt), 32'd1);

        // Five more hazards: 16-bit counter reaches 6, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 5'd1, 5'd0, 5'd2, 32'h11, 32'h0, 32'h4);
            tick();
            set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 5'd3, 5'd2, 5'd5, 32'h1, 32'h1, 32'h0);
            tick();
        end
        chk("sat_cnt16", 32'(bubble_cnt), 32'd6);
        chk("sat_cnt2", 32'(d2_bubble_cnt), 32'd3);

        // Asynchronous reset pulse between edges
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hf, 5'd4, 5'd5, 5'd12, 32'hFFFF0000, 32'h5, 32'h6);
        tick();
        chk("pre_rst_valid", 32'(evalid), 32'd1);
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        chk("async_rst_cnt2", 32'(d2_bubble_cnt), 32'd0);
        #1 rst = 1'b0;
        tick();

        // Reset while frozen discards the held instruction; next edge loads normally
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 5'd1, 5'd0, 5'd11, 32'h21, 32'h0, 32'h0);
        tick();
        exe_stall = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1 chk("stall_rst_valid", 32'(evalid), 32'd0);
        exe_stall = 1'b0;
        set_id(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 5'd1, 5'd0, 5'd9, 32'h31, 32'h0, 32'h0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(evalid), 32'd1);
        chk("post_rst_dest", {27'd0, edestReg}, 32'd9);

        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
